register_file: RTL and testbench

//   32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
//   - Two combinational read ports feed the ALU operand paths.
//   - One synchronous write port is driven by the writeback stage.
//   - Register 0 is hardwired to zero, per the MIPS ISA.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/register_file_if.sv | 23 ++
 rtl/regfile_read_port.sv | 37 +++
 rtl/register_file.sv | 45 ++++
 tb/tb_register_file.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, counts and types for the MIPS general-purpose register file.
package regfile_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_COUNT      = 2 ** REG_ADDR_WIDTH;

  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: two read ports plus the writeback write port.
interface register_file_if;
  import regfile_pkg::*;

  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  reg_addr_t WriteRegister;
  reg_data_t WriteData;
  logic      RegWrite;
  reg_data_t ReadData1;
  reg_data_t ReadData2;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, r0 forcing, optional write-through.
// Write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_addr_t addr,
  input  reg_data_t regs [REG_COUNT],
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  output reg_data_t data_c
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    data_c = regs[addr];
    if (we && (waddr != REG_ZERO) && (addr == waddr)) begin
      data_c = wdata;
    end
    if (addr == REG_ZERO) begin
      data_c = '0;
    end
  end
`else
  // Write-port signals are only consumed by the forwarding path.
  logic unused_write;
  assign unused_write = &{1'b0, we, waddr, wdata};

  always_comb begin
    data_c = regs[addr];
    if (addr == REG_ZERO) begin
      data_c = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: sync reset, one write port, two comb read ports.
// Optional same-cycle write-through on the reads when REGFILE_BYPASS_EN is defined.
module register_file
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  bus
);

  localparam int unsigned DATA_WIDTH = REG_DATA_WIDTH;
  localparam int unsigned ADDR_WIDTH = REG_ADDR_WIDTH;

  reg_data_t regs [REG_COUNT];

  // Reset clears everything and beats a concurrent write; r0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (bus.RegWrite && (bus.WriteRegister != REG_ZERO)) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  regfile_read_port u_read_port1 (
    .addr   (bus.ReadRegister1),
    .regs   (regs),
    .we     (bus.RegWrite),
    .waddr  (bus.WriteRegister),
    .wdata  (bus.WriteData),
    .data_c (bus.ReadData1)
  );

  regfile_read_port u_read_port2 (
    .addr   (bus.ReadRegister2),
    .regs   (regs),
    .we     (bus.RegWrite),
    .waddr  (bus.WriteRegister),
    .wdata  (bus.WriteData),
    .data_c (bus.ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected reads, monitor compares.
module tb_register_file;

  logic clk;
  logic reset;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t exp_q[$];
  logic obs_valid;
  logic end_req;
  logic end_done;
  int   checks;
  int   failures;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLLIDE_EXP = 32'hCAFEF00D;
`else
  localparam logic [31:0] COLLIDE_EXP = 32'h00000000;
`endif

  // Monitor: compare both read ports mid-cycle whenever a sample is presented.
  always @(negedge clk) begin
    exp_t e;
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: sample presented with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.ReadData1 !== e.e1) begin
          failures++;
          $display("FAIL %s port1 got=%h exp=%h", e.name, bus.ReadData1, e.e1);
        end
        checks++;
        if (bus.ReadData2 !== e.e2) begin
          failures++;
          $display("FAIL %s port2 got=%h exp=%h", e.name, bus.ReadData2, e.e2);
        end
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain leftover=%0d exp=0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.WriteRegister = a;
    bus.WriteData     = d;
    bus.RegWrite      = 1'b1;
    @(posedge clk); #1;
    bus.RegWrite      = 1'b0;
  endtask

  task automatic check(input string name, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    bus.ReadRegister1 = r1;
    bus.ReadRegister2 = r2;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
    obs_valid = 1'b1;
    @(posedge clk); #1;
    obs_valid = 1'b0;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    obs_valid         = 1'b0;
    end_req           = 1'b0;
    end_done          = 1'b0;
    reset             = 1'b0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    bus.RegWrite      = 1'b0;
    @(posedge clk); #1;

    // Reset clears storage.
    do_reset();
    check("reset_r0_r5", 5'd0, 5'd5, 32'h0, 32'h0);
    check("reset_r31_r5", 5'd31, 5'd5, 32'h0, 32'h0);

    // Basic writes and reads.
    write_reg(5'd5, 32'hFFFFFFFF);
    check("write_r5", 5'd5, 5'd0, 32'hFFFFFFFF, 32'h0);
    write_reg(5'd2, 32'hDEADBEEF);
    check("write_r2", 5'd2, 5'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
    write_reg(5'd2, 32'h00000000);
    check("overwrite_r2", 5'd2, 5'd5, 32'h0, 32'hFFFFFFFF);

    // r0 stays zero.
    write_reg(5'd0, 32'h12345678);
    check("r0_readonly", 5'd0, 5'd0, 32'h0, 32'h0);

    // Top index, same index on both ports, and RegWrite=0 holding state.
    write_reg(5'd31, 32'h0F1E2D3C);
    check("r31_both", 5'd31, 5'd31, 32'h0F1E2D3C, 32'h0F1E2D3C);
    bus.WriteRegister = 5'd31;
    bus.WriteData     = 32'h55555555;
    bus.RegWrite      = 1'b0;
    @(posedge clk); #1;
    check("regwrite_low_hold", 5'd31, 5'd5, 32'h0F1E2D3C, 32'hFFFFFFFF);

    // Reset beats a write in the same cycle.
    bus.WriteRegister = 5'd7;
    bus.WriteData     = 32'hA5A5A5A5;
    bus.RegWrite      = 1'b1;
    reset             = 1'b1;
    @(posedge clk); #1;
    reset             = 1'b0;
    bus.RegWrite      = 1'b0;
    check("reset_wins_r7_r5", 5'd7, 5'd5, 32'h0, 32'h0);
    check("reset_wins_r31_r2", 5'd31, 5'd2, 32'h0, 32'h0);

    // Read/write collision on r9: old value (or forwarded) before edge, new after.
    bus.WriteRegister = 5'd9;
    bus.WriteData     = 32'hCAFEF00D;
    bus.RegWrite      = 1'b1;
    check("collide_pre_edge", 5'd9, 5'd0, COLLIDE_EXP, 32'h0);
    bus.RegWrite      = 1'b0;
    check("collide_post_edge", 5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D);

    // Writing r0 never forwards.
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 32'h87654321;
    bus.RegWrite      = 1'b1;
    check("r0_no_forward", 5'd0, 5'd9, 32'h0, 32'hCAFEF00D);
    bus.RegWrite      = 1'b0;

    end_req = 1'b1;
    for (int i = 0; i < 4 && !end_done; i++) begin
      @(posedge clk); #1;
    end
    if (!end_done) begin
      $display("FAIL end_handshake monitor did not drain");
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
